dbg_uart_loader: RTL and testbench
==================================

# dbg_uart_loader

Hardware successor to bench-side `force`-based program preloading. Receives a byte-framed command stream from the UART receiver and drives the SoC debug memory port (`dbg_mem_op`/`dbg_wren`/`dbg_adr`/`dbg_do`) to burst-write or read-back-verify words at any address. It holds `cpu_n_reset` low until a run command arrives. Data width, address width, access latency and inter-byte timeout are parameters. It sits between the UART RX/TX byte interfaces and the debug mux in front of the bus arbiter.

## Interface
Parameters:
- `DATA_W`, 32: debug word width; a multiple of 8. `NB = DATA_W/8`.
- `ADR_W`, 32: debug address width; must be ≥ 16.
- `WR_CYCLES`, 2: cycles `dbg_mem_op` is held per write; must be ≥ 1.
- `RD_CYCLES`, 2: cycles `dbg_mem_op` is held per read; `dbg_di` is sampled on the last one. Must be ≥ 1.
- `TIMEOUT`, 100000: maximum idle cycles between bytes inside a frame.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `n_reset` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; there is no backpressure.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response valid.
- `tx_ready` in 1: UART TX accepts the byte.
- `dbg_mem_op` out 1: debug bus access request.
- `dbg_wren` out NB: byte write enables.
- `dbg_adr` out ADR_W: byte address, NB-aligned.
- `dbg_do` out DATA_W: write data.
- `dbg_di` in DATA_W: read data.
- `cpu_n_reset` out 1: CPU reset, active low.
- `busy` out 1: a frame is in progress.
- `err_cnt` out 8: errors in the current/last frame, saturating at 255.

## Operation
- Frame format: command byte, then 4 address bytes (LE), then 2 count bytes N (LE), then N·NB data bytes (LE within each word).
  - `0x57` 'W': write each word.
  - `0x56` 'V': read each word and compare.
- Single-byte commands:
  - `0x47` 'G': set `cpu_n_reset=1`, reply `0x06`.
  - `0x48` 'H': set `cpu_n_reset=0`, reply `0x06`.
  - Any other byte in IDLE: reply `0x3F`, no other effect.
- Address handling: only the low ADR_W bits of the 32-bit field are used. The low log2(NB) bits are forced to 0. The address increments by NB after each word and wraps modulo 2^ADR_W.
- State machine:
  - IDLE → ADR(4 bytes) → CNT(2 bytes) → DATA (or FLUSH if N=0).
  - DATA → FLUSH after the N-th word is assembled.
  - FLUSH → RESP once no access is pending.
  - RESP → IDLE on `tx_ready`.
- Buffering: words are assembled in a shift register. A completed word moves into a one-entry access buffer, so assembly of the next word overlaps the bus access.
- Overrun: a word completes while the buffer is still occupied. The new word is dropped, `err_cnt`+1, and its address is still consumed.
- Write access: `dbg_wren` = all ones, `dbg_adr`/`dbg_do` are stable for the whole access.
- Verify access: `dbg_wren` = 0. A mismatch between `dbg_di` and the buffered word increments `err_cnt`.
- Response: `0x06` if `err_cnt`==0, else `0x15`. `err_cnt` is cleared when a new W/V command byte is accepted.
- Timeout: if TIMEOUT cycles pass with no `rx_valid` while in ADR/CNT/DATA, `err_cnt`+1 and the block goes to FLUSH, then RESP (reply `0x15`).
- Bytes received while in FLUSH or RESP are discarded.
- `rx_valid` during RESP in the same cycle as `tx_ready`: the byte is discarded.

## Timing
- Reset values: `cpu_n_reset=0`, `dbg_mem_op=0`, `dbg_wren=0`, `dbg_adr=0`, `dbg_do=0`, `tx_valid=0`, `tx_data=0`, `busy=0`, `err_cnt=0`, state IDLE.
- A mid-frame reset aborts immediately and drives `cpu_n_reset` low.
- Access start: `dbg_mem_op` rises the cycle after the last byte of a word is strobed (if the buffer is free).
  - It is high for exactly WR_CYCLES or RD_CYCLES cycles.
  - `dbg_wren`/`dbg_adr`/`dbg_do` are zero whenever `dbg_mem_op`=0.
- Back-to-back accesses: at least 1 idle cycle between accesses.
- `tx_valid` rises the cycle after FLUSH completes and stays high, with `tx_data` stable, until sampled with `tx_ready`=1.
- G/H response: `tx_valid` one cycle after the byte. `cpu_n_reset` changes on that same cycle.
- `busy` = 1 from the cycle after a W/V byte until the response handshake.
- `cpu_n_reset` is unchanged by W/V frames. Loading while the CPU runs is allowed.

## Test plan
- Write frame: `57 00 00 01 00 03 00` + words 0x55, 0x66, 0x77 (DATA_W=32). Expect three writes to 0x10000/0x10004/0x10008, each with `dbg_wren`=F and 2-cycle `dbg_mem_op`, then `tx_data`=06.
- Verify frame: same data against a memory model. Expect 06. Corrupt 0x10004 and repeat: expect 15, `err_cnt`=1.
- Go/halt: `47` gives `cpu_n_reset`=1 plus reply 06. `48` returns it to 0. Byte `5A` gives reply 3F with no bus activity.
- Boundaries: address 0xFFFFFFFC, N=2 → writes at FFFFFFFC then 00000000. N=0 → immediate 06 with no access. Address 0x103 → aligned to 0x100.
- Stress: stop after 5 data bytes, wait TIMEOUT+1 cycles → one write then 15. Bytes strobed every cycle with WR_CYCLES=8 → overrun counted, 15.
- Reset mid-DATA: all outputs return to reset values asynchronously. The next frame completes normally.

Source files
------------

// File: rtl/dbg_uart_loader.sv
// dbg_uart_loader: decodes a byte-framed UART command stream into debug-port
// burst writes / read-back verifies and controls the CPU reset line.
module dbg_uart_loader #(
    parameter int DATA_W    = 32,
    parameter int ADR_W     = 32,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2,
    parameter int TIMEOUT   = 100000
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                dbg_mem_op,
    output logic [DATA_W/8-1:0] dbg_wren,
    output logic [ADR_W-1:0]    dbg_adr,
    output logic [DATA_W-1:0]   dbg_do,
    input  logic [DATA_W-1:0]   dbg_di,
    output logic                cpu_n_reset,
    output logic                busy,
    output logic [7:0]          err_cnt
);

    localparam int NB      = DATA_W / 8;
    // One shift register serves address (32 bit), count (16 bit) and data.
    localparam int SH_W    = (DATA_W > 32) ? DATA_W : 32;
    localparam int BC_MAX  = (NB > 4) ? NB : 4;
    localparam int BC_W    = $clog2(BC_MAX);
    localparam int ACC_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int PH_W    = (ACC_MAX > 1) ? $clog2(ACC_MAX) : 1;
    localparam int TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [ADR_W-1:0] ALIGN_MASK = ~(ADR_W'(NB - 1));

    localparam logic [7:0] CMD_WRITE  = 8'h57;
    localparam logic [7:0] CMD_VERIFY = 8'h56;
    localparam logic [7:0] CMD_GO     = 8'h47;
    localparam logic [7:0] CMD_HALT   = 8'h48;
    localparam logic [7:0] RSP_ACK    = 8'h06;
    localparam logic [7:0] RSP_NAK    = 8'h15;
    localparam logic [7:0] RSP_UNK    = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADR,
        S_CNT,
        S_DATA,
        S_FLUSH,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    // Frame assembly
    logic [BC_W-1:0]   byte_cnt_q;
    logic [SH_W-9:0]   sh_q;
    logic [SH_W-1:0]   sh_next;
    logic [TO_W-1:0]   idle_cnt_q;
    logic [31:0]       adr_field;
    logic [15:0]       cnt_field;
    logic [DATA_W-1:0] word_field;
    logic [ADR_W-1:0]  word_adr_q;
    logic [15:0]       words_left_q;
    logic              is_write_q;

    // One-entry access buffer
    logic              buf_valid_q;
    logic [ADR_W-1:0]  buf_adr_q;
    logic [DATA_W-1:0] buf_data_q;
    logic [PH_W-1:0]   acc_cnt_q;
    logic [PH_W-1:0]   acc_last_idx;

    // Status / response
    logic [7:0]        err_cnt_q;
    logic [7:0]        tx_data_q;
    logic              busy_q;
    logic              cpu_run_q;

    // Decoded events
    logic              in_frame;
    logic              is_frame_cmd;
    logic              frame_start;
    logic              word_done;
    logic              accept;
    logic              overrun;
    logic              acc_last;
    logic              mismatch;
    logic              timeout_hit;
    logic [1:0]        err_inc;
    logic [8:0]        err_sum;

    assign in_frame     = (state_q == S_ADR) || (state_q == S_CNT) || (state_q == S_DATA);
    assign is_frame_cmd = (rx_data == CMD_WRITE) || (rx_data == CMD_VERIFY);
    assign frame_start  = (state_q == S_IDLE) && rx_valid && is_frame_cmd;

    // Bytes arrive LE, so shifting in at the top leaves the last field in the MSBs.
    assign sh_next    = {rx_data, sh_q};
    assign adr_field  = sh_next[SH_W-1 -: 32];
    assign cnt_field  = sh_next[SH_W-1 -: 16];
    assign word_field = sh_next[SH_W-1 -: DATA_W];

    assign word_done   = (state_q == S_DATA) && rx_valid && (byte_cnt_q == BC_W'(NB - 1));
    assign accept      = word_done && !buf_valid_q;
    assign overrun     = word_done && buf_valid_q;
    assign timeout_hit = in_frame && !rx_valid && (idle_cnt_q == TO_W'(TIMEOUT - 1));

    assign acc_last_idx = is_write_q ? PH_W'(WR_CYCLES - 1) : PH_W'(RD_CYCLES - 1);
    assign acc_last     = buf_valid_q && (acc_cnt_q == acc_last_idx);
    assign mismatch     = acc_last && !is_write_q && (dbg_di != buf_data_q);

    // Mismatch may coincide with a timeout or an overrun, so sum the sources.
    assign err_inc = 2'(overrun) + 2'(mismatch) + 2'(timeout_hit);
    assign err_sum = {1'b0, err_cnt_q} + {7'd0, err_inc};

    // State register
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    // NOTE: state_d gets a default first so no branch leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) state_d = is_frame_cmd ? S_ADR : S_RESP;
            end
            S_ADR: begin
                if (timeout_hit)                                 state_d = S_FLUSH;
                else if (rx_valid && byte_cnt_q == BC_W'(3))     state_d = S_CNT;
            end
            S_CNT: begin
                if (timeout_hit)                                 state_d = S_FLUSH;
                else if (rx_valid && byte_cnt_q == BC_W'(1))
                    state_d = (cnt_field == 16'd0) ? S_FLUSH : S_DATA;
            end
            S_DATA: begin
                if (timeout_hit)                                 state_d = S_FLUSH;
                else if (word_done && words_left_q == 16'd1)     state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (!buf_valid_q) state_d = S_RESP;
            end
            S_RESP: begin
                if (tx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: bus signals are forced to zero whenever no access is in flight
    always_comb begin
        tx_valid    = (state_q == S_RESP);
        tx_data     = tx_data_q;
        busy        = busy_q;
        cpu_n_reset = cpu_run_q;
        err_cnt     = err_cnt_q;
        dbg_mem_op  = buf_valid_q;
        dbg_wren    = (buf_valid_q && is_write_q) ? '1 : '0;
        dbg_adr     = buf_valid_q ? buf_adr_q : '0;
        dbg_do      = (buf_valid_q && is_write_q) ? buf_data_q : '0;
    end

    // Byte counter, shift register and inter-byte idle timer
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            byte_cnt_q <= '0;
            sh_q       <= '0;
            idle_cnt_q <= '0;
        end else begin
            if (state_d != state_q)
                byte_cnt_q <= '0;
            else if (rx_valid && in_frame)
                byte_cnt_q <= (byte_cnt_q == BC_W'(NB - 1) && state_q == S_DATA) ? '0
                                                                                  : byte_cnt_q + 1'b1;
            if (rx_valid && in_frame)
                sh_q <= sh_next[SH_W-1:8];
            if (!in_frame || rx_valid)
                idle_cnt_q <= '0;
            else
                idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    // Frame header capture: operation, aligned start address, word count
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            is_write_q   <= 1'b0;
            word_adr_q   <= '0;
            words_left_q <= '0;
        end else begin
            if (frame_start)
                is_write_q <= (rx_data == CMD_WRITE);
            if (state_q == S_ADR && rx_valid && byte_cnt_q == BC_W'(3))
                word_adr_q <= adr_field[ADR_W-1:0] & ALIGN_MASK;
            else if (word_done)
                // Dropped words still consume their address slot.
                word_adr_q <= word_adr_q + ADR_W'(NB);
            if (state_q == S_CNT && rx_valid && byte_cnt_q == BC_W'(1))
                words_left_q <= cnt_field;
            else if (word_done)
                words_left_q <= words_left_q - 16'd1;
        end
    end

    // Access buffer: holds one word while the bus access runs; freed on the
    // last access cycle so the next access follows after one idle cycle
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            buf_valid_q <= 1'b0;
            buf_adr_q   <= '0;
            buf_data_q  <= '0;
            acc_cnt_q   <= '0;
        end else if (accept) begin
            buf_valid_q <= 1'b1;
            buf_adr_q   <= word_adr_q;
            buf_data_q  <= word_field;
            acc_cnt_q   <= '0;
        end else if (buf_valid_q) begin
            if (acc_last) buf_valid_q <= 1'b0;
            else          acc_cnt_q   <= acc_cnt_q + 1'b1;
        end
    end

    // Error counter: cleared by a new frame command, saturates at 255
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            err_cnt_q <= '0;
        else if (frame_start)
            err_cnt_q <= '0;
        else if (err_inc != 2'd0)
            err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // Response byte, busy flag and CPU reset control
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            cpu_run_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && rx_valid) begin
                if (rx_data == CMD_GO) begin
                    cpu_run_q <= 1'b1;
                    tx_data_q <= RSP_ACK;
                end else if (rx_data == CMD_HALT) begin
                    cpu_run_q <= 1'b0;
                    tx_data_q <= RSP_ACK;
                end else if (!is_frame_cmd) begin
                    tx_data_q <= RSP_UNK;
                end
            end
            if (state_q == S_FLUSH && !buf_valid_q)
                tx_data_q <= (err_cnt_q == 8'd0) ? RSP_ACK : RSP_NAK;
            if (frame_start)
                busy_q <= 1'b1;
            else if (state_q == S_RESP && tx_ready)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dbg_uart_loader.sv
// tb_dbg_uart_loader: randomized and directed frames against a transaction-level
// model of the loader. Instance a uses 2-cycle accesses; instance b uses
// 8-cycle writes so back-to-back words overrun its buffer.
module tb_dbg_uart_loader;

    localparam int WRC   = 2;
    localparam int RDC   = 2;
    localparam int WRC_B = 8;
    localparam int TO    = 40;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [7:0]  rx_data;
    logic        rx_valid_a, rx_valid_b, tx_ready;

    logic [7:0]  tx_data_a, err_a, tx_data_b, err_b;
    logic        tx_valid_a, mem_op_a, cpu_a, busy_a;
    logic        tx_valid_b, mem_op_b, cpu_b, busy_b;
    logic [3:0]  wren_a, wren_b;
    logic [31:0] adr_a, do_a, di_a, adr_b, do_b, di_b;

    dbg_uart_loader #(.DATA_W(32), .ADR_W(32), .WR_CYCLES(WRC), .RD_CYCLES(RDC), .TIMEOUT(TO)) u_dut (
        .clk(clk), .n_reset(n_reset), .rx_data(rx_data), .rx_valid(rx_valid_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .dbg_mem_op(mem_op_a), .dbg_wren(wren_a), .dbg_adr(adr_a), .dbg_do(do_a), .dbg_di(di_a),
        .cpu_n_reset(cpu_a), .busy(busy_a), .err_cnt(err_a)
    );

    dbg_uart_loader #(.DATA_W(32), .ADR_W(32), .WR_CYCLES(WRC_B), .RD_CYCLES(RDC), .TIMEOUT(TO)) u_dut_ovr (
        .clk(clk), .n_reset(n_reset), .rx_data(rx_data), .rx_valid(rx_valid_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .dbg_mem_op(mem_op_b), .dbg_wren(wren_b), .dbg_adr(adr_b), .dbg_do(do_b), .dbg_di(di_b),
        .cpu_n_reset(cpu_b), .busy(busy_b), .err_cnt(err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Target memory seen through the debug port of instance a
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  wren;
        logic [31:0] data;
        int          len;
        bit          stable;
    } acc_t;

    acc_t acc_q[$];
    acc_t cur;
    bit   prev_op_a = 1'b0;
    bit   prev_op_b = 1'b0;
    int   zero_viol = 0;
    int   acc_b     = 0;

    // Bus monitor, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (mem_op_a) begin
            if (!prev_op_a) begin
                cur.adr = adr_a; cur.wren = wren_a; cur.data = do_a; cur.len = 1; cur.stable = 1'b1;
            end else begin
                if (adr_a != cur.adr || wren_a != cur.wren || do_a != cur.data) cur.stable = 1'b0;
                cur.len++;
            end
        end else begin
            if (prev_op_a) begin
                acc_q.push_back(cur);
                if (cur.wren == 4'hF) mem[cur.adr] = cur.data;
            end
            if (wren_a != 4'h0 || adr_a != 32'h0 || do_a != 32'h0) zero_viol++;
        end
        prev_op_a = mem_op_a;
        if (mem_op_b && !prev_op_b) acc_b++;
        prev_op_b = mem_op_b;
        di_a = mem_rd(adr_a);
    end

    bit          to_b = 1'b0;
    int          last_err = 0;
    logic [31:0] fw [$];

    function automatic logic sel_txv();
        return to_b ? tx_valid_b : tx_valid_a;
    endfunction
    function automatic logic [7:0] sel_txd();
        return to_b ? tx_data_b : tx_data_a;
    endfunction
    function automatic logic sel_busy();
        return to_b ? busy_b : busy_a;
    endfunction
    function automatic logic [7:0] sel_err();
        return to_b ? err_b : err_a;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, output int stamp);
        @(negedge clk);
        rx_data = b;
        if (to_b) rx_valid_b = 1'b1;
        else      rx_valid_a = 1'b1;
        @(posedge clk);
        stamp = cyc;
        #1;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] adr, input int n, input int gap);
        int st;
        send_byte(cmd, gap, st);
        for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8], gap, st);
        send_byte(n[7:0], gap, st);
        send_byte(n[15:8], gap, st);
    endtask

    task automatic get_resp(input logic [7:0] exp_data, input logic [7:0] exp_err,
                            input logic exp_busy, input string tag);
        int n;
        n = 0;
        while (!sel_txv() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_txv"}, 32'(sel_txv()), 32'd1);
        check({tag, "_data"}, 32'(sel_txd()), 32'(exp_data));
        check({tag, "_err"}, 32'(sel_err()), 32'(exp_err));
        check({tag, "_busy"}, 32'(sel_busy()), 32'(exp_busy));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check({tag, "_hold"}, {23'd0, sel_txv(), sel_txd()}, {23'd0, 1'b1, exp_data});
        @(negedge clk);
        tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, {30'd0, sel_txv(), sel_busy()}, 32'd0);
    endtask

    task automatic do_single(input logic [7:0] b, input logic [7:0] reply,
                             input logic exp_cpu, input string tag);
        int st;
        acc_q.delete();
        send_byte(b, 0, st);
        @(negedge clk);
        check({tag, "_txv1"}, 32'(tx_valid_a), 32'd1);
        check({tag, "_cpu"}, 32'(cpu_a), 32'(exp_cpu));
        get_resp(reply, 8'(last_err), 1'b0, tag);
        check({tag, "_nobus"}, acc_q.size(), 32'd0);
    endtask

    // Expected bus accesses follow from when each word's last byte lands:
    // a word is taken only if the previous access (start+1 .. start+L) is over.
    task automatic do_frame(input logic [7:0] cmd, input logic [31:0] adr, input int n,
                            input int nsend, input int gap, input string tag);
        int          st, last, l, err;
        bit          wr;
        logic [31:0] a, w;
        acc_t        e;
        acc_t        exp_q[$];
        wr   = (cmd == 8'h57);
        l    = to_b ? WRC_B : (wr ? WRC : RDC);
        last = -100000;
        err  = 0;
        a    = adr & ~32'h3;
        acc_q.delete();
        acc_b     = 0;
        zero_viol = 0;
        send_hdr(cmd, adr, n, gap);
        for (int i = 0; i < nsend; i++) begin
            w = fw[i/4];
            send_byte(w[8*(i%4) +: 8], gap, st);
            if (i % 4 == 3) begin
                if (st > last + l) begin
                    e.adr = a; e.wren = wr ? 4'hF : 4'h0; e.data = w; e.len = l; e.stable = 1'b1;
                    exp_q.push_back(e);
                    last = st;
                    if (!wr && mem_rd(a) != w) err++;
                end else begin
                    err++;
                end
                a += 32'd4;
            end
        end
        if (nsend < 4 * n) err++;
        if (err > 255) err = 255;
        last_err = err;
        get_resp((err == 0) ? 8'h06 : 8'h15, 8'(err), 1'b1, tag);
        if (to_b) begin
            check({tag, "_nacc"}, acc_b, exp_q.size());
        end else begin
            check({tag, "_nacc"}, acc_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
                check({tag, "_adr"}, acc_q[k].adr, exp_q[k].adr);
                check({tag, "_wren"}, 32'(acc_q[k].wren), 32'(exp_q[k].wren));
                check({tag, "_len"}, acc_q[k].len, exp_q[k].len);
                check({tag, "_stable"}, 32'(acc_q[k].stable), 32'd1);
                if (wr) check({tag, "_wdata"}, acc_q[k].data, exp_q[k].data);
            end
            check({tag, "_zero_idle"}, zero_viol, 32'd0);
        end
    endtask

    task automatic fill_words(input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back($urandom());
    endtask

    initial begin
        int          st, n, k;
        logic [31:0] base, ca;
        n_reset    = 1'b0;
        rx_data    = 8'h00;
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
        tx_ready   = 1'b0;
        di_a       = 32'h0;
        di_b       = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_txv",  32'(tx_valid_a), 32'd0);
        check("rst_txd",  32'(tx_data_a),  32'd0);
        check("rst_op",   32'(mem_op_a),   32'd0);
        check("rst_bus",  {28'd0, wren_a} | adr_a | do_a, 32'd0);
        check("rst_cpu",  32'(cpu_a),      32'd0);
        check("rst_busy", 32'(busy_a),     32'd0);
        check("rst_err",  32'(err_a),      32'd0);
        @(negedge clk) n_reset = 1'b1;

        // Directed write / verify / corrupted verify
        fw = '{32'h55, 32'h66, 32'h77};
        do_frame(8'h57, 32'h0001_0000, 3, 12, 1, "wr3");
        do_frame(8'h56, 32'h0001_0000, 3, 12, 0, "vf3");
        mem[32'h0001_0004] = mem_rd(32'h0001_0004) ^ 32'h1;
        do_frame(8'h56, 32'h0001_0000, 3, 12, 2, "vf3bad");
        mem[32'h0001_0004] = 32'h66;

        // Single-byte commands
        do_single(8'h47, 8'h06, 1'b1, "go");
        do_single(8'h48, 8'h06, 1'b0, "halt");
        do_single(8'h5A, 8'h3F, 1'b0, "unk");

        // Address wrap, empty frame, unaligned start
        fill_words(2);
        do_frame(8'h57, 32'hFFFF_FFFC, 2, 8, 0, "wrap");
        fill_words(0);
        do_frame(8'h57, $urandom(), 0, 0, 1, "n0");
        fill_words(1);
        do_frame(8'h57, 32'h0000_0103, 1, 4, 0, "unal");

        // Randomized write + verify, sometimes with a corrupted target word
        for (int r = 0; r < 6; r++) begin
            n    = $urandom_range(1, 5);
            base = $urandom();
            fill_words(n);
            do_frame(8'h57, base, n, 4 * n, $urandom_range(0, 3), "rwr");
            if ($urandom_range(0, 1) == 1) begin
                k  = $urandom_range(0, n - 1);
                ca = (base & ~32'h3) + 32'(4 * k);
                mem[ca] = mem_rd(ca) ^ (32'h1 << $urandom_range(0, 31));
            end
            do_frame(8'h56, base, n, 4 * n, $urandom_range(0, 3), "rvf");
        end

        // Inter-byte timeout after 5 data bytes
        fill_words(3);
        do_frame(8'h57, $urandom(), 3, 5, 0, "tmo");

        // CPU keeps running across a load
        do_single(8'h47, 8'h06, 1'b1, "go2");
        fill_words(2);
        do_frame(8'h57, $urandom(), 2, 8, 1, "runld");
        check("runld_cpu", 32'(cpu_a), 32'd1);

        // Overrun on the slow-write instance
        to_b = 1'b1;
        fill_words(4);
        do_frame(8'h57, $urandom(), 4, 16, 0, "ovr");
        to_b = 1'b0;

        // Asynchronous reset in the middle of a write access
        fill_words(4);
        send_hdr(8'h57, $urandom(), 4, 0);
        for (int i = 0; i < 4; i++) send_byte(fw[0][8*i +: 8], 0, st);
        @(negedge clk);
        check("mid_op_pre", 32'(mem_op_a), 32'd1);
        #2 n_reset = 1'b0;
        #1;
        check("mid_op",   32'(mem_op_a), 32'd0);
        check("mid_bus",  {28'd0, wren_a} | adr_a | do_a, 32'd0);
        check("mid_cpu",  32'(cpu_a), 32'd0);
        check("mid_flag", {22'd0, tx_valid_a, busy_a, err_a}, 32'd0);
        @(negedge clk) n_reset = 1'b1;
        last_err = 0;
        fill_words(2);
        do_frame(8'h57, 32'h0000_2000, 2, 8, 0, "post_wr");
        do_frame(8'h56, 32'h0000_2000, 2, 8, 1, "post_vf");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
